// File: rtl/bcd_sub_seq.sv
// bcd_sub_seq: digit-serial packed-BCD subtractor producing sign-magnitude A - B.
// One decimal digit per clock, least-significant first; a negative difference
// is left as a ten's complement after the first pass and re-complemented in place.
module bcd_sub_seq #(
    parameter int unsigned NDIG = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic [4*NDIG-1:0] A,
    input  logic [4*NDIG-1:0] B,
    output logic              BUSY,
    output logic              DONE,
    output logic [4*NDIG-1:0] D,
    output logic              NEG,
    output logic              ERR
);

    localparam int unsigned W  = 4 * NDIG;
    localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

    // S_ERR holds BUSY for the single cycle between accepting a bad operand
    // and the DONE cycle, so the error path reports one edge after acceptance.
    typedef enum logic [2:0] {
        S_IDLE,
        S_SUB,
        S_COMP,
        S_ERR,
        S_FIN
    } state_t;

    state_t        state_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  d_q;
    logic [IW-1:0] idx_q;
    logic          borrow_q;
    logic          busy_q;
    logic          done_q;
    logic          neg_q;
    logic          err_q;

    logic [3:0]    a_dig;
    logic [3:0]    b_dig;
    logic [4:0]    diff_d;
    logic [3:0]    dig_d;
    logic          bout_d;

    function automatic logic has_bad(input logic [W-1:0] x);
        logic bad;
        bad = 1'b0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (x[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // One BCD digit step; during COMP the minuend is 0 and the subtrahend is D itself.
    always_comb begin
        a_dig  = '0;
        b_dig  = '0;
        if (state_q == S_COMP) begin
            a_dig = 4'd0;
            b_dig = d_q[4*idx_q +: 4];
        end else begin
            a_dig = a_q[4*idx_q +: 4];
            b_dig = b_q[4*idx_q +: 4];
        end
        diff_d = {1'b0, a_dig} - {1'b0, b_dig} - {4'd0, borrow_q};
        bout_d = diff_d[4];
        dig_d  = diff_d[4] ? (diff_d[3:0] + 4'd10) : diff_d[3:0];
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_FIN: begin
                    done_q <= 1'b0;
                    if (START) begin
                        a_q      <= A;
                        b_q      <= B;
                        d_q      <= '0;
                        neg_q    <= 1'b0;
                        idx_q    <= '0;
                        borrow_q <= 1'b0;
                        busy_q   <= 1'b1;
                        if (has_bad(A) || has_bad(B)) begin
                            err_q   <= 1'b1;
                            state_q <= S_ERR;
                        end else begin
                            err_q   <= 1'b0;
                            state_q <= S_SUB;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_SUB: begin
                    d_q[4*idx_q +: 4] <= dig_d;
                    if (idx_q == LAST) begin
                        idx_q    <= '0;
                        borrow_q <= 1'b0;
                        if (bout_d) begin
                            neg_q   <= 1'b1;
                            state_q <= S_COMP;
                        end else begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end
                    end else begin
                        idx_q    <= idx_q + 1'b1;
                        borrow_q <= bout_d;
                    end
                end
                S_COMP: begin
                    d_q[4*idx_q +: 4] <= dig_d;
                    if (idx_q == LAST) begin
                        idx_q    <= '0;
                        borrow_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_FIN;
                    end else begin
                        idx_q    <= idx_q + 1'b1;
                        borrow_q <= bout_d;
                    end
                end
                S_ERR: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_FIN;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign D    = d_q;
    assign NEG  = neg_q;
    assign ERR  = err_q;

endmodule

// File: tb/tb_bcd_sub_seq.sv
// tb_bcd_sub_seq: directed vectors for bcd_sub_seq with a decimal-arithmetic
// reference model checked every cycle, plus literal expectations per operation.
module tb_bcd_sub_seq;

    localparam int unsigned N = 2;
    localparam int unsigned W = 4 * N;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         neg;
    logic         err;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    bcd_sub_seq #(.NDIG(N)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .START (start),
        .A     (a),
        .B     (b),
        .BUSY  (busy),
        .DONE  (done),
        .D     (d),
        .NEG   (neg),
        .ERR   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (decimal arithmetic) ----------------
    function automatic bit bad_bcd(input logic [W-1:0] x);
        bit r;
        r = 1'b0;
        for (int i = 0; i < N; i++) if (x[4*i +: 4] > 4'd9) r = 1'b1;
        return r;
    endfunction

    function automatic int bcd2int(input logic [W-1:0] x);
        int v;
        v = 0;
        for (int i = N - 1; i >= 0; i--) v = v * 10 + int'(x[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < N; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int absdiff(input logic [W-1:0] x, input logic [W-1:0] y);
        int dv;
        dv = bcd2int(x) - bcd2int(y);
        return (dv < 0) ? -dv : dv;
    endfunction

    logic         m_busy, m_done, m_neg, m_err;
    logic [W-1:0] m_d;
    logic         p_neg, p_err;
    logic [W-1:0] p_d;
    int           m_cnt;

    initial begin
        m_busy = 0; m_done = 0; m_neg = 0; m_err = 0; m_d = '0;
        p_neg = 0; p_err = 0; p_d = '0; m_cnt = 0;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy <= 0; m_done <= 0; m_d <= '0; m_neg <= 0; m_err <= 0; m_cnt <= 0;
        end else if (!m_busy && start) begin
            m_busy <= 1; m_done <= 0; m_d <= '0; m_neg <= 0; m_err <= 0;
            p_err  <= bad_bcd(a) || bad_bcd(b);
            p_neg  <= !(bad_bcd(a) || bad_bcd(b)) && (bcd2int(a) < bcd2int(b));
            p_d    <= (bad_bcd(a) || bad_bcd(b)) ? '0 : int2bcd(absdiff(a, b));
            m_cnt  <= (bad_bcd(a) || bad_bcd(b)) ? 1 :
                      ((bcd2int(a) < bcd2int(b)) ? 2 * N : N);
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                m_busy <= 0; m_done <= 1; m_d <= p_d; m_neg <= p_neg; m_err <= p_err;
            end
            m_cnt <= m_cnt - 1;
        end else begin
            m_done <= 0;
        end
    end

    // Per-cycle comparison; result outputs are only meaningful while not busy.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (busy !== m_busy || done !== m_done) begin
                errors++;
                $display("FAIL cyc_hs busy=%b done=%b required busy=%b done=%b", busy, done, m_busy, m_done);
            end
            if (!m_busy) begin
                checks++;
                if (d !== m_d || neg !== m_neg || err !== m_err) begin
                    errors++;
                    $display("FAIL cyc_res d=%h neg=%b err=%b required d=%h neg=%b err=%b",
                             d, neg, err, m_d, m_neg, m_err);
                end
            end
        end
    end

    // ---------------- literal checks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, act, exp);
        end
    endtask

    // Caller is at a negedge. Optionally pokes START with other operands one cycle later.
    task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] exp_d, input bit exp_neg, input bit exp_err,
                          input int exp_lat, input bit poke);
        int n;
        start = 1'b1; a = av; b = bv;
        @(negedge clk);
        start = 1'b0;
        a = 8'h11; b = 8'h22;
        n = 1;
        if (poke) begin
            start = 1'b1; a = 8'h99; b = 8'h00;
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_lat"}, 32'(n), 32'(exp_lat + 1));
        chk({name, "_d"},   32'(d), 32'(exp_d));
        chk({name, "_neg"}, 32'(neg), 32'(exp_neg));
        chk({name, "_err"}, 32'(err), 32'(exp_err));
    endtask

    task automatic idle(input int c);
        repeat (c) @(negedge clk);
    endtask

    initial begin
        int dones;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_d",    32'(d),    32'd0);
        chk("rst_flags", 32'({neg, err}), 32'd0);
        rst_n = 1'b1;
        idle(1);

        run_op("pos83_27", 8'h83, 8'h27, 8'h56, 0, 0, 2, 0);
        idle(2);
        run_op("neg27_83", 8'h27, 8'h83, 8'h56, 1, 0, 4, 1);
        idle(1);
        run_op("neg00_99", 8'h00, 8'h99, 8'h99, 1, 0, 4, 0);
        idle(1);
        run_op("pos99_00", 8'h99, 8'h00, 8'h99, 0, 0, 2, 0);
        idle(1);
        run_op("eq45",     8'h45, 8'h45, 8'h00, 0, 0, 2, 0);
        idle(1);
        run_op("err3A_10", 8'h3A, 8'h10, 8'h00, 0, 1, 1, 0);
        // Back-to-back: each START lands in the previous DONE cycle.
        run_op("clr_err",  8'h83, 8'h27, 8'h56, 0, 0, 2, 0);
        run_op("b2b50_01", 8'h50, 8'h01, 8'h49, 0, 0, 2, 0);
        run_op("b2b_neg",  8'h12, 8'h30, 8'h18, 1, 0, 4, 0);
        idle(2);

        // Abort a negative operation with reset one edge after acceptance.
        start = 1'b1; a = 8'h27; b = 8'h83;
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_out", 32'({busy, done, neg, err}), 32'd0);
        chk("abort_d", 32'(d), 32'd0);
        rst_n = 1'b1;
        dones = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("abort_nodone", 32'(dones), 32'd0);
        run_op("post10_01", 8'h10, 8'h01, 8'h09, 0, 0, 2, 0);
        idle(3);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
